// File: rtl/sum_accumulator.sv
// sum_accumulator
// Accumulates frames of N unsigned samples from the registered adder stage
// into an ACC_W-bit running total. Each completed total is offered on a
// valid/ready port. The adder cannot be stalled, so any sample that arrives
// while a total is still waiting is discarded and recorded in a sticky flag.
//
// Optional build macro: SUM_ACC_SAT_EN
//   defined   -> the accumulator saturates at 2^ACC_W-1 within a frame
//   undefined -> the accumulator wraps modulo 2^ACC_W
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data carries a new adder result this cycle
//   in_data    adder sum, unsigned, DATA_W bits
//   in_ready   status only: a sample arriving this cycle will be accepted
//   out_valid  a frame total is presented
//   out_ready  downstream accepts the total
//   out_sum    frame total, ACC_W bits
//   out_frame  index of the presented frame, wraps 255 -> 0
//   drop       sticky: a valid sample was discarded (cleared by reset only)

module sum_accumulator #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 4,
  parameter int unsigned ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [7:0]        out_frame,
  output logic              drop
);

  localparam int unsigned CNT_W = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;

  logic [ACC_W-1:0]   data_ext;
  logic [ACC_W-1:0]   acc_add;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last;

  assign data_ext = ACC_W'(in_data);

`ifdef SUM_ACC_SAT_EN
  // One extra bit catches the carry; once pinned at all-ones the value
  // stays there because every further add carries out again.
  logic [ACC_W:0] sum_full;
  assign sum_full = {1'b0, acc} + {1'b0, data_ext};
  assign acc_add  = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign acc_add  = acc + data_ext;
`endif

  assign cnt_inc  = cnt + 1'b1;
  assign last     = (cnt_inc == N_LAST);

  // Status only: upstream cannot stall, this just tells it what will happen.
  assign in_ready = (state == ACCUM) || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_frame <= '0;
      drop      <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_add;
            if (last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= acc_add;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_frame <= out_frame + 8'd1;
            if (in_valid) begin
              // Sample rides the handshake as first sample of the next frame.
              acc <= data_ext;
              if (N == 1) begin
                // Single-sample frames complete immediately: stay presenting.
                out_sum <= data_ext;
                cnt     <= '0;
              end else begin
                state     <= ACCUM;
                out_valid <= 1'b0;
                cnt       <= CNT_W'(1);
              end
            end else begin
              state     <= ACCUM;
              out_valid <= 1'b0;
              acc       <= '0;
              cnt       <= '0;
            end
          end else if (in_valid) begin
            drop <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator. Three instances with different N and
// ACC_W share one randomized/directed stimulus stream. Each instance has a
// frame-level reference model that pushes expected totals into a queue; a
// negedge monitor pops and compares on every output handshake.

module tb_sum_accumulator;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int NG = (g == 0) ? 4 : (g == 1) ? 1 : 3;
    localparam int AW = (g == 0) ? 10 : 8;

    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_sum;
    logic [7:0]    out_frame;
    logic          drop;

    sum_accumulator #(.DATA_W(8), .N(NG), .ACC_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_frame (out_frame),
      .drop      (drop)
    );

    // Frame-level reference: true integer sum per frame, folded at the end.
    bit m_hold, m_drop, acc_ok;
    int m_sum, m_cnt, m_frame;
    int q_sum[$];
    int q_frame[$];

    function automatic int fold(input int s);
`ifdef SUM_ACC_SAT_EN
      return (s > (1 << AW) - 1) ? (1 << AW) - 1 : s;
`else
      return s % (1 << AW);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_hold = 0; m_drop = 0; m_sum = 0; m_cnt = 0; m_frame = 0;
        q_sum.delete(); q_frame.delete();
      end else begin
        if (m_hold && in_valid && !out_ready) m_drop = 1;
        acc_ok = in_valid && (!m_hold || out_ready);
        if (m_hold && out_ready) begin
          m_hold  = 0;
          m_frame = (m_frame + 1) % 256;
        end
        if (acc_ok) begin
          m_sum += int'(in_data);
          m_cnt++;
          if (m_cnt == NG) begin
            q_sum.push_back(fold(m_sum));
            q_frame.push_back(m_frame);
            m_hold = 1; m_sum = 0; m_cnt = 0;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        chk($sformatf("g%0d out_valid", g), 32'(out_valid), 32'(m_hold));
        chk($sformatf("g%0d drop", g), 32'(drop), 32'(m_drop));
        chk($sformatf("g%0d in_ready", g), 32'(in_ready), 32'(!m_hold || out_ready));
        if (out_valid && out_ready) begin
          if (q_sum.size() == 0) begin
            chk($sformatf("g%0d unexpected total", g), 32'(out_sum), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("g%0d out_sum", g), 32'(out_sum), 32'(q_sum.pop_front()));
            chk($sformatf("g%0d out_frame", g), 32'(out_frame), 32'(q_frame.pop_front()));
          end
        end
      end
    end

    task automatic chk_zero();
      chk($sformatf("g%0d rst out_valid", g), 32'(out_valid), 0);
      chk($sformatf("g%0d rst out_sum", g), 32'(out_sum), 0);
      chk($sformatf("g%0d rst out_frame", g), 32'(out_frame), 0);
      chk($sformatf("g%0d rst drop", g), 32'(drop), 0);
    endtask
  end

`ifdef SUM_ACC_SAT_EN
  localparam int OVF_EXP = 255;
`else
  localparam int OVF_EXP = 253;   // 3*255 = 765 mod 256
`endif

  // Drive inputs just after an edge; return just after the edge that samples them.
  task automatic step(input bit iv, input logic [7:0] d, input bit r);
    in_valid  = iv;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0;
    #3 rst = 1'b1;
    #1;
    gi[0].chk_zero(); gi[1].chk_zero(); gi[2].chk_zero();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; out_ready = 0;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame on the N=4 instance
    step(1, 10, 1); step(1, 20, 1); step(1, 30, 1); step(1, 40, 1);
    chk("basic out_sum", 32'(gi[0].out_sum), 100);
    chk("basic out_valid", 32'(gi[0].out_valid), 1);
    chk("basic out_frame0", 32'(gi[0].out_frame), 0);
    step(0, 0, 1);
    chk("basic valid one cycle", 32'(gi[0].out_valid), 0);
    chk("basic out_frame1", 32'(gi[0].out_frame), 1);

    // Backpressure with drops
    step(1, 10, 1); step(1, 20, 1); step(1, 30, 1); step(1, 40, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'($urandom), 0);
      chk("bp out_sum hold", 32'(gi[0].out_sum), 100);
      chk("bp drop", 32'(gi[0].drop), 1);
      chk("bp in_ready", 32'(gi[0].in_ready), 0);
    end
    step(0, 0, 1);
    chk("bp release", 32'(gi[0].out_valid), 0);
    step(1, 1, 1); step(1, 2, 1); step(1, 3, 1); step(1, 4, 1);
    chk("bp fresh frame", 32'(gi[0].out_sum), 10);

    // Handshake together with a sample
    step(1, 7, 1);
    chk("hs+sample out_valid", 32'(gi[0].out_valid), 0);
    step(1, 1, 1); step(1, 1, 1); step(1, 1, 1);
    chk("hs+sample out_sum", 32'(gi[0].out_sum), 10);
    chk("hs+sample out_valid2", 32'(gi[0].out_valid), 1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6);

    // Asynchronous reset mid-run, then N=1 streaming and overflow
    do_reset();
    step(1, 5, 1);
    chk("n1 sum5", 32'(gi[1].out_sum), 5);
    chk("n1 frame0", 32'(gi[1].out_frame), 0);
    step(1, 6, 1);
    chk("n1 sum6", 32'(gi[1].out_sum), 6);
    chk("n1 frame1", 32'(gi[1].out_frame), 1);
    chk("n1 no drop", 32'(gi[1].drop), 0);
    step(1, 7, 0);
    chk("n1 sum held", 32'(gi[1].out_sum), 6);
    chk("n1 drop", 32'(gi[1].drop), 1);
    step(0, 0, 1);
    step(1, 255, 1); step(1, 255, 1); step(1, 255, 1);
    chk("overflow out_sum", 32'(gi[2].out_sum), 32'(OVF_EXP));
    chk("overflow out_valid", 32'(gi[2].out_valid), 1);

    // Sustained streaming: never a drop
    do_reset();
    for (int i = 0; i < 300; i++) step(1, 8'($urandom), 1);
    chk("stream g0 drop", 32'(gi[0].drop), 0);
    chk("stream g1 drop", 32'(gi[1].drop), 0);
    chk("stream g2 drop", 32'(gi[2].drop), 0);

    // More random traffic with light backpressure
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 8, 8'($urandom), $urandom_range(0, 9) < 8);

    in_valid = 0; out_ready = 0;
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
